// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions and write masks.
package cp0_defs;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_BEV   = 22;
  localparam int CA_BD    = 31;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;

  localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances every other cycle, timer_int latches on a Compare match.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;
  logic        inc;

  assign inc = tick_q & ~count_we_i;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_we_i ? wdata_i : compare_q;
    timer_d   = timer_q;
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (inc) begin
      count_d = count_q + 32'd1;
    end
    // A Compare write clears the flag even if a match lands in the same cycle.
    if (compare_we_i) begin
      timer_d = 1'b0;
    end else if (inc && (count_q + 32'd1 == compare_q)) begin
      timer_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MTC0/MFC0, exception entry / ERET redirect, interrupt pending.
// Define CP0_RD_BYPASS_EN to forward same-cycle MTC0 data onto rdata_o.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic        exception_i,
  input  logic [5:0]  cause_i,
  input  logic        eret_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [5:0]  int_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        int_pending_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] count, compare;
  logic        timer_int;
  logic        exl;

  assign exl = status_q[ST_EXL];

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && (waddr_i == CP0_COUNT)),
    .compare_we_i (we_i && (waddr_i == CP0_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int)
  );

  // MTC0 applies first; exception/ERET then override only the fields they own.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    if (we_i) begin
      case (waddr_i)
        CP0_STATUS: status_d = apply_mask(status_q, wdata_i, STATUS_WMASK);
        CP0_CAUSE:  cause_d  = apply_mask(cause_q, wdata_i, CAUSE_WMASK);
        CP0_EPC:    epc_d    = wdata_i;
        default:    ;
      endcase
    end
    if (exception_i) begin
      status_d[ST_EXL] = 1'b1;
      cause_d[CA_EXC_HI:CA_EXC_LO] = cause_i[4:0];
      if (!exl) begin
        epc_d        = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
        cause_d[CA_BD] = in_delay_slot_i;
      end
      if (cause_i == 6'(EXC_ADEL) || cause_i == 6'(EXC_ADES)) begin
        badv_d = badvaddr_i;
      end
    end else if (eret_i) begin
      status_d[ST_EXL] = 1'b0;
    end
    cause_d[15:10] = {int_i[5] | timer_int, int_i[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
      badv_q   <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      badv_q   <= badv_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badv_q;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
`ifdef CP0_RD_BYPASS_EN
    if (we_i && (waddr_i == raddr_i)) begin
      case (waddr_i)
        CP0_COUNT, CP0_COMPARE, CP0_EPC: rdata_o = wdata_i;
        CP0_STATUS: rdata_o = apply_mask(status_q, wdata_i, STATUS_WMASK);
        CP0_CAUSE:  rdata_o = apply_mask(cause_q, wdata_i, CAUSE_WMASK);
        default:    ;
      endcase
    end
`endif
  end

  assign flush_o  = exception_i | eret_i;
  assign new_pc_o = exception_i ? EXC_VECTOR : (eret_i ? epc_q : 32'h0);

  assign int_pending_o = status_q[ST_IE] & ~exl & (|(cause_q[15:8] & status_q[15:8]));

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_int;

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- CP0 responder for the 5-stage MIPS pipeline, on the far side of the controller's exception_o / eret_o / cause_o outputs.
- Holds the BadVAddr, Count, Compare, Status, Cause and EPC registers, and serves MTC0/MFC0 accesses.
- Produces flush and redirect-PC signals for exception entry and ERET.
- Implements the Count/Compare timer and computes pending interrupts for the pipeline.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect PC on exception entry.
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 register number
- rdata_o  out  32  MFC0 data, combinational from current register state
- exception_i  in  1  exception taken this cycle (from controller exception_o)
- cause_i  in  6  exception cause code (from controller cause_o; bits [4:0] used)
- eret_i  in  1  ERET executing
- pc_i  in  32  PC of the excepting instruction
- in_delay_slot_i  in  1  excepting instruction is in a branch delay slot
- badvaddr_i  in  32  faulting address for AdEL/AdES
- int_i  in  6  hardware interrupt lines, level-sensitive
- flush_o  out  1  flush pipeline (combinational, exception_i|eret_i)
- new_pc_o  out  32  redirect target, valid while flush_o=1
- int_pending_o  out  1  unmasked interrupt pending
- status_o, cause_o, epc_o  out  32 each  current register values
- timer_int_o  out  1  timer interrupt flag

Behaviour:
- Reset (rst=1 at posedge):
  - Status=STATUS_RESET; Cause=0, EPC=0, Count=0, Compare=0, BadVAddr=0.
  - timer_int=0; tick=0.
  - All registered outputs reflect these values on the next cycle.
  - Reset overrides every other event in the same cycle.
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other address reads 0 and ignores writes.
- MTC0 write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV[22] stays 1; all other bits read 0.
  - Cause: only IP[9:8] are writable.
  - BadVAddr: read-only.
  - Count and Compare: all 32 bits writable.
- Cause.IP[15:10]: sampled each cycle from int_i. IP[15] = int_i[5] | timer_int.
- Count:
  - 1-bit tick toggles every cycle; Count increments when tick=1, giving half clock rate.
  - Wraps 32'hFFFF_FFFF -> 0.
  - MTC0 to Count loads wdata_i and clears tick.
- Timer:
  - timer_int sets on the cycle Count increments to a value equal to Compare.
  - It stays set until any MTC0 write to Compare, which clears it. A clear and a set in the same cycle resolve to clear.
- Exception entry (exception_i=1):
  - If EXL=0: EPC <= in_delay_slot_i ? pc_i-4 : pc_i; Cause.BD[31] <= in_delay_slot_i.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1; Cause.ExcCode[6:2] <= cause_i[4:0].
  - If cause_i is 4 or 5: BadVAddr <= badvaddr_i.
  - flush_o=1, new_pc_o=EXC_VECTOR in the same cycle.
- ERET (eret_i=1, exception_i=0): EXL <= 0; flush_o=1; new_pc_o = the current EPC register value.
- Same-cycle priority is exception > ERET > MTC0. The losing MTC0 is dropped only for the fields the winner modifies; the write still lands in other registers.
- int_pending_o = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). This is combinational from the registers.
- rdata_o returns the pre-write value. There is no write-to-read bypass unless the optional feature below is enabled.
- new_pc_o is 0 when flush_o=0.

Optional Feature:
- Macro: CP0_RD_BYPASS_EN.
- Defined: rdata_o forwards wdata_i when we_i=1 and waddr_i==raddr_i, with the write masks applied.
- Undefined: rdata_o always shows the registered value.

Decomposition:
- Shared package cp0_defs holds:
  - register numbers (CP0_BADVADDR=8 through CP0_EPC=14);
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - Status/Cause bit positions and write masks;
  - the EXC_VECTOR value.
- One sub-module, cp0_timer: the Count/Compare/tick/timer_int logic. Its interface is the write strobes plus count_o, compare_o and timer_int_o.

Test Plan:
- Reset then read: raddr=12 -> rdata_o=32'h0040_0000; raddr=9 -> 0; after 10 cycles Count=5.
- Syscall at pc_i=32'h8000_0100, delay slot=0 -> EPC=32'h8000_0100, ExcCode=8, EXL=1, flush_o=1, new_pc_o=32'hBFC0_0380. Then eret_i -> EXL=0, new_pc_o=32'h8000_0100.
- Nested exception with EXL=1: cause 9 at pc_i=32'h8000_0200 -> EPC stays 32'h8000_0100, ExcCode=9. Delay-slot exception at 32'h8000_0300 with EXL=0 -> EPC=32'h8000_02FC, BD=1.
- Timer: write Compare=3, Count=0 -> timer_int_o rises when Count becomes 3 (about 6 cycles later). With Status=32'h0040_8001, int_pending_o=1. Writing Compare clears it.
- Priority: exception_i and MTC0 EPC=32'h1234 in the same cycle -> EPC = exception value. MTC0 Status=32'hFFFF_FFFF -> reads back 32'h0040_FF03.
- AdEL (cause 4) with badvaddr_i=32'h0000_0003 -> BadVAddr=3; MTC0 to register 8 ignored.
